seg7_monitor: RTL
=================

# seg7_monitor

Receive-side companion to the seven-segment seconds counter: samples a 7-bit segment bus, filters it for stability, decodes each settled pattern back to a digit, and checks that digits advance in count order. It also measures the clock-cycle interval between successive digit changes. It sits on the board-test and loopback path, with `seg_in` wired to the counter's segment outputs or to an external display bus.

## Interface
- `STABLE_CYCLES`, 16: synchronized pattern must hold this many consecutive cycles before it is accepted (≥2).
- `WRAP_DIGIT`, 9: highest digit in the count sequence; the successor of `WRAP_DIGIT` is 0.
- `CNT_W`, 24: width of the interval counter.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `seg_in` in 7: segment bus, active-high; bit0=a … bit6=g. Asynchronous to `clk`.
- `digit_out` out 4: last accepted digit.
- `digit_valid` out 1: one-cycle pulse when a new digit is accepted.
- `blank` out 1: level; the last accepted pattern was all-off.
- `bad_pulse` out 1: one-cycle pulse when an undecodable pattern is accepted.
- `bad_count` out 8: count of accepted undecodable patterns; saturates at 255.
- `seq_error` out 1: sticky; an out-of-order digit was seen.
- `interval` out CNT_W: cycles between the previous two accepted digits.
- `interval_valid` out 1: one-cycle pulse when `interval` updates.

## Operation
- Input path: 2-flop synchronizer, then a candidate register with a stability counter.
  - The counter clears whenever the synchronized value differs from the candidate.
  - Acceptance happens when the counter reaches `STABLE_CYCLES-1` **and** the candidate differs from the last accepted pattern. Each settled pattern is accepted exactly once.
- Decode (hex, 0x prefix):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - 00 is blank.
  - Every other pattern is bad.
- FSM states: EMPTY, FIRST, RUN.
  - EMPTY (after reset): no digit accepted yet. A valid digit moves to FIRST. No interval is reported and no sequence check is made.
  - FIRST: one reference digit held. The next valid digit moves to RUN and is sequence-checked.
  - RUN: every valid digit is sequence-checked.
- Blank accepted:
  - `blank`=1, `digit_out` held, no `digit_valid`.
  - State returns to EMPTY; sequence checking and the interval restart.
  - A valid digit clears `blank`.
- Bad pattern accepted:
  - `bad_pulse`, `bad_count`+1 (saturating).
  - `digit_out`, `blank` and the state are unchanged.
  - The bad pattern becomes the last accepted pattern, so it is not recounted while held.
- Sequence rule, applied in FIRST→RUN and in RUN:
  - The new digit must equal prev+1, or 0 when prev==`WRAP_DIGIT`.
  - Any other value, including a digit >`WRAP_DIGIT`, sets `seq_error` until reset. Monitoring continues, with the new digit as prev.
- Interval:
  - A free-running counter clears on each valid-digit acceptance and saturates at all-ones.
  - On acceptance in FIRST or RUN, `interval` is loaded with the counter value + 1 (cycles since the previous acceptance) and `interval_valid` pulses together with `digit_valid`.

## Timing
- Reset values:
  - `digit_out`=0, `digit_valid`=0, `blank`=0, `bad_pulse`=0, `bad_count`=0, `seq_error`=0, `interval`=0, `interval_valid`=0.
  - State EMPTY; synchronizer, candidate and last-accepted registers all 0.
  - Because last-accepted resets to 0, a blank bus after reset is never re-accepted.
- Latency: a pattern first present at `seg_in` before edge N and held produces `digit_valid` in the cycle after edge N+1+`STABLE_CYCLES`, i.e. `STABLE_CYCLES`+2 cycles.
- A glitch shorter than `STABLE_CYCLES` cycles produces no output.
- Reset mid-filter discards the pending candidate. Reset has priority over acceptance in the same cycle.
- `digit_valid`, `bad_pulse` and `interval_valid` are never high together with `blank` transitioning 0→1.

## Configuration
- `SEG7_MONITOR_INTERVAL_EN` defined: interval counter, `interval` and `interval_valid` are implemented as above.
- Not defined: the counter is removed, `interval` is tied to 0 and `interval_valid` to 0. All other behaviour is identical.

## Structure
- Shared package `seg7_pkg` holds:
  - the ten digit pattern constants and the blank constant;
  - the pattern-to-digit decode function, returning a valid flag;
  - the FSM state enum.
- One sub-module, `seg7_stabilizer`: synchronizer, candidate register, stability counter, last-accepted register. It outputs an accept pulse plus the accepted pattern.

## Test plan
- Reset, then hold 3F, then 06, each for 100 cycles (`STABLE_CYCLES`=16):
  - `digit_valid` 18 cycles after each change; `digit_out` 0 then 1.
  - `interval`=100 at the second digit; `seq_error`=0.
- Drive 0…9 then 0, each for 50 cycles: ten `interval_valid` pulses with `interval`=50; `seq_error` stays 0 across the 9→0 wrap.
- Drive 3F, 06, then 4F (3): `seq_error` set at 4F and still 1 after 1000 more correct digits; cleared only by reset.
- Pulse 7F for 10 cycles between stable 06 and 5B: no acceptance of 7F; `digit_out` goes 1→2 with no `seq_error`.
- Hold 49 (bad) for 40 cycles, twice, separated by 5B:
  - `bad_pulse` twice, `bad_count`=2, `digit_out` unchanged by the bad patterns.
  - 300 bad patterns saturate `bad_count` at 255.
- Sequence 06, 00, 4F:
  - `blank`=1 after 00; 4F accepted with no `seq_error` and no `interval_valid`.
  - Assert `reset` 5 cycles into a new pattern: no `digit_valid` follows.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment monitor: segment pattern constants,
// the pattern-to-digit decoder and the monitor FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FIRST,
    ST_RUN
  } monState_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] digit;
  } decode_t;

  // Blank is deliberately reported as not-valid; callers test for it separately.
  function automatic decode_t decodeSeg(input logic [6:0] pattern);
    decode_t res;
    res.valid = 1'b1;
    res.digit = 4'd0;
    case (pattern)
      SEG_0:   res.digit = 4'd0;
      SEG_1:   res.digit = 4'd1;
      SEG_2:   res.digit = 4'd2;
      SEG_3:   res.digit = 4'd3;
      SEG_4:   res.digit = 4'd4;
      SEG_5:   res.digit = 4'd5;
      SEG_6:   res.digit = 4'd6;
      SEG_7:   res.digit = 4'd7;
      SEG_8:   res.digit = 4'd8;
      SEG_9:   res.digit = 4'd9;
      default: res.valid = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_stabilizer.sv
// Synchronizes the asynchronous segment bus and emits a single accept pulse
// once a new pattern has held steady for STABLE_CYCLES cycles.
module seg7_stabilizer
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_i,
  output logic       accept_o,
  output logic [6:0] pattern_o
);

  localparam int            CW      = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 2);

  logic [6:0]    sync1_q, sync2_q;
  logic [6:0]    cand_q, cand_d;
  logic [6:0]    last_q, last_d;
  logic [CW-1:0] stableCnt_q, stableCnt_d;
  logic          accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= SEG_BLANK;
      sync2_q <= SEG_BLANK;
    end else begin
      sync1_q <= seg_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept on the edge where the counter reaches its final value; the counter
  // then parks there, and last_q blocks re-acceptance of a returning pattern.
  always_comb begin
    accept      = (sync2_q == cand_q) && (stableCnt_q == CNT_PRE) && (cand_q != last_q);
    cand_d      = cand_q;
    stableCnt_d = stableCnt_q;
    last_d      = last_q;
    if (sync2_q != cand_q) begin
      cand_d      = sync2_q;
      stableCnt_d = '0;
    end else if (stableCnt_q != CNT_MAX) begin
      stableCnt_d = stableCnt_q + CW'(1);
    end
    if (accept) begin
      last_d = cand_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q      <= SEG_BLANK;
      last_q      <= SEG_BLANK;
      stableCnt_q <= '0;
    end else begin
      cand_q      <= cand_d;
      last_q      <= last_d;
      stableCnt_q <= stableCnt_d;
    end
  end

  assign accept_o  = accept;
  assign pattern_o = cand_q;

endmodule

// File: rtl/seg7_monitor.sv
// Decodes settled seven-segment patterns, checks digits advance in count order
// and, with SEG7_MONITOR_INTERVAL_EN defined, measures cycles between digits.
module seg7_monitor
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int WRAP_DIGIT    = 9,
  parameter int CNT_W         = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit_out,
  output logic             digit_valid,
  output logic             blank,
  output logic             bad_pulse,
  output logic [7:0]       bad_count,
  output logic             seq_error,
  output logic [CNT_W-1:0] interval,
  output logic             interval_valid
);

  localparam logic [3:0] WRAP_D = 4'(WRAP_DIGIT);

  logic       accept;
  logic [6:0] accPattern;
  decode_t    dec;
  logic       isBlank, isDigit, isBad, checkSeq;
  logic [3:0] expDigit;

  monState_e  state_q, state_d;
  logic [3:0] digit_q, digit_d;
  logic       digitValid_q, digitValid_d;
  logic       blank_q, blank_d;
  logic       badPulse_q, badPulse_d;
  logic [7:0] badCount_q, badCount_d;
  logic       seqError_q, seqError_d;

  seg7_stabilizer #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stabilizer (
    .clk      (clk),
    .reset    (reset),
    .seg_i    (seg_in),
    .accept_o (accept),
    .pattern_o(accPattern)
  );

  assign dec      = decodeSeg(accPattern);
  assign isBlank  = accept && (accPattern == SEG_BLANK);
  assign isDigit  = accept && dec.valid;
  assign isBad    = accept && !dec.valid && (accPattern != SEG_BLANK);
  assign checkSeq = isDigit && (state_q != ST_EMPTY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Bad patterns leave the state alone; blank forgets the reference digit.
  always_comb begin
    state_d = state_q;
    if (isBlank) begin
      state_d = ST_EMPTY;
    end else if (isDigit) begin
      case (state_q)
        ST_EMPTY: state_d = ST_FIRST;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    digit_d      = digit_q;
    digitValid_d = 1'b0;
    blank_d      = blank_q;
    badPulse_d   = 1'b0;
    badCount_d   = badCount_q;
    seqError_d   = seqError_q;
    expDigit     = (digit_q == WRAP_D) ? 4'd0 : digit_q + 4'd1;
    if (isDigit) begin
      digit_d      = dec.digit;
      digitValid_d = 1'b1;
      blank_d      = 1'b0;
      if (checkSeq && ((dec.digit != expDigit) || (dec.digit > WRAP_D))) begin
        seqError_d = 1'b1;
      end
    end
    if (isBlank) begin
      blank_d = 1'b1;
    end
    if (isBad) begin
      badPulse_d = 1'b1;
      if (badCount_q != 8'hFF) begin
        badCount_d = badCount_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q      <= 4'd0;
      digitValid_q <= 1'b0;
      blank_q      <= 1'b0;
      badPulse_q   <= 1'b0;
      badCount_q   <= 8'd0;
      seqError_q   <= 1'b0;
    end else begin
      digit_q      <= digit_d;
      digitValid_q <= digitValid_d;
      blank_q      <= blank_d;
      badPulse_q   <= badPulse_d;
      badCount_q   <= badCount_d;
      seqError_q   <= seqError_d;
    end
  end

  assign digit_out   = digit_q;
  assign digit_valid = digitValid_q;
  assign blank       = blank_q;
  assign bad_pulse   = badPulse_q;
  assign bad_count   = badCount_q;
  assign seq_error   = seqError_q;

`ifdef SEG7_MONITOR_INTERVAL_EN
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic [CNT_W-1:0] ivCnt_q, ivCnt_d;
  logic [CNT_W-1:0] interval_q, interval_d;
  logic             intervalValid_q, intervalValid_d;

  // Reported interval is counter+1 because the counter restarts at zero on the
  // accepting edge itself.
  always_comb begin
    ivCnt_d         = ivCnt_q;
    interval_d      = interval_q;
    intervalValid_d = 1'b0;
    if (isDigit) begin
      ivCnt_d = '0;
    end else if (ivCnt_q != CNT_SAT) begin
      ivCnt_d = ivCnt_q + CNT_W'(1);
    end
    if (checkSeq) begin
      intervalValid_d = 1'b1;
      interval_d      = (ivCnt_q == CNT_SAT) ? CNT_SAT : ivCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ivCnt_q         <= '0;
      interval_q      <= '0;
      intervalValid_q <= 1'b0;
    end else begin
      ivCnt_q         <= ivCnt_d;
      interval_q      <= interval_d;
      intervalValid_q <= intervalValid_d;
    end
  end

  assign interval       = interval_q;
  assign interval_valid = intervalValid_q;
`else
  assign interval       = '0;
  assign interval_valid = 1'b0;
`endif

endmodule
